// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and state encoding for the instruction fetch sequencer
package fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - 4-bit load/decrement counter timing instruction memory settle
module fetch_wait_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - PC owner and fetch controller for a fixed-delay instruction memory
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int unsigned       RD_WAIT  = 2,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 64'h58
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] inst_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic [15:0]        count_q, count_d;

  logic               timer_load, timer_dec, timer_zero;
  logic               handshake, running;
  logic [ADDR_W-1:0]  seq_pc;

  fetch_wait_timer u_wait_timer (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (timer_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    count_d    = count_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    seq_pc     = pc_q + PC_STEP;
    handshake  = (state_q == VALID) && valid_q && inst_ready;
    running    = (state_q == ADDR) || (state_q == WAIT) || (state_q == VALID);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        timer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (timer_zero) begin
          inst_d   = imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = VALID;
        end else begin
          timer_dec = 1'b1;
        end
      end
      VALID: begin
        if (handshake) begin
          valid_d = 1'b0;
          count_d = count_q + 16'd1;
          if (seq_pc > PC_LIMIT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = seq_pc;
            addr_d  = seq_pc;
            state_d = ADDR;
          end
        end
      end
      HALT: begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect wins over the sequential path and abandons any capture this cycle;
    // a handshake in the same cycle has already been counted above.
    if (redirect_valid && running) begin
      valid_d   = 1'b0;
      inst_d    = inst_q;
      pc_out_d  = pc_out_q;
      timer_dec = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d  = 1'b1;
        halted_d = 1'b1;
        pc_d     = pc_q;
        addr_d   = addr_q;
        state_d  = HALT;
      end else begin
        halted_d = halted_q;
        pc_d     = redirect_pc;
        addr_d   = redirect_pc;
        state_d  = ADDR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      inst_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr   = addr_q;
  assign inst_out    = inst_q;
  assign pc_out      = pc_out_q;
  assign inst_valid  = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule
